// File: rtl/apb_slave_timer_pkg.sv
// Shared constants for the APB timer: register offsets, CTRL bit positions, default base.
// Imported by the top-level decode and register file.
package apb_timer_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_A000;

  localparam int OFS_PERIOD = 0;
  localparam int OFS_CTRL   = 1;
  localparam int OFS_COUNT  = 2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/apb_slave_timer_counter.sv
// Up-counter with period expiry: count/timeout update one edge after en/period are sampled.
// No backpressure; clr zeroes the count on the same edge and never suppresses an expiry pulse.
module timer_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic [W-1:0] count,
  output logic         timeout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (en) begin
        // >= lets a shrunken period force expiry rather than running past it
        if (period == '0) begin
          count <= '0;
        end else if (count >= period - W'(1)) begin
          count   <= '0;
          timeout <= 1'b1;
        end else begin
          count <= count + W'(1);
        end
      end
      if (clr) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/apb_slave_timer.sv
// APB zero-wait-state slave holding PERIOD/CTRL/COUNT around an 8-bit expiry timer.
// pready = psel & penable; writes land on the edge ending ACCESS, reads are combinational.
module apb_slave_timer
  import apb_timer_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEFAULT)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              timeout
);

  logic              access;
  logic              wr;
  logic              rd;
  logic              hit_period;
  logic              hit_ctrl;
  logic              hit_count;
  logic              clr;
  logic              en_q;
  logic [DATA_W-1:0] period_q;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] ctrl_rd;

  assign access = psel & penable;
  assign wr     = access & pwrite;
  assign rd     = access & ~pwrite;
  assign pready = access;

  assign hit_period = (paddr == BASE_ADDR + ADDR_W'(OFS_PERIOD));
  assign hit_ctrl   = (paddr == BASE_ADDR + ADDR_W'(OFS_CTRL));
  assign hit_count  = (paddr == BASE_ADDR + ADDR_W'(OFS_COUNT));

  // CLR is a strobe only; it is never stored
  assign clr = wr & hit_ctrl & pwdata[CTRL_CLR];

  always_ff @(posedge pclk) begin
    if (preset) begin
      period_q <= '0;
      en_q     <= 1'b0;
    end else if (wr) begin
      if (hit_period) period_q <= pwdata;
      if (hit_ctrl)   en_q     <= pwdata[CTRL_EN];
    end
  end

  // Counter sees the pre-write en/period, so a start counts from the next edge
  timer_counter #(.W(DATA_W)) u_counter (
    .clk     (pclk),
    .rst     (preset),
    .en      (en_q),
    .clr     (clr),
    .period  (period_q),
    .count   (count),
    .timeout (timeout)
  );

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[CTRL_EN] = en_q;
  end

  always_comb begin
    prdata = '0;
    if (rd) begin
      if (hit_period)     prdata = period_q;
      else if (hit_ctrl)  prdata = ctrl_rd;
      else if (hit_count) prdata = count;
    end
  end

endmodule

// File: tb/tb_apb_slave_timer.sv
// Bench for apb_slave_timer: directed register/timing scenarios plus randomized APB traffic
// checked every cycle against a behavioural model of the register map and timer.
module tb_apb_slave_timer;

  localparam logic [31:0] BASE = 32'h0000_A000;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pready;
  logic        timeout;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  int m_period = 0;
  int m_en = 0;
  int m_count = 0;
  int m_to = 0;
  int nc;
  int nt;

  apb_slave_timer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .timeout (timeout)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: a timer expires when the next enabled edge would make count reach period.
  always @(posedge pclk) begin
    if (preset) begin
      m_period = 0; m_en = 0; m_count = 0; m_to = 0;
    end else begin
      nt = 0;
      nc = m_count;
      if (m_en != 0) begin
        if (m_period == 0) nc = 0;
        else if (m_count + 1 >= m_period) begin nc = 0; nt = 1; end
        else nc = m_count + 1;
      end
      if (psel && penable && pwrite) begin
        if (paddr == BASE) m_period = int'(pwdata);
        else if (paddr == BASE + 32'd1) begin
          m_en = int'(pwdata[0]);
          if (pwdata[1]) nc = 0;
        end
      end
      m_count = nc;
      m_to = nt;
    end
  end

  function automatic int exp_rd();
    if (!(psel && penable && !pwrite)) return 0;
    if (paddr == BASE) return m_period;
    if (paddr == BASE + 32'd1) return m_en;
    if (paddr == BASE + 32'd2) return m_count;
    return 0;
  endfunction

  always @(negedge pclk) begin
    if (chk_on) begin
      chk("pready", int'(pready), int'(psel && penable));
      chk("prdata", int'(prdata), exp_rd());
      chk("timeout", int'(timeout), m_to);
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic apb_write(input logic [31:0] a, input int d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = 8'(d);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input int exp, input bit lit, input string nm);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    if (lit) begin
      chk(nm, int'(prdata), exp);
      chk({nm, "_pready"}, int'(pready), 1);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // Edges until timeout is seen high, bounded.
  task automatic edges_to_pulse(output int n);
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!timeout && n < 600);
  endtask

  initial begin
    int n;
    int p;
    logic [31:0] a;
    int d;

    preset = 1'b1;
    idle(2);
    preset = 1'b0;
    chk_on = 1'b1;

    // Reset state and idle reads
    #1;
    chk("rst_prdata", int'(prdata), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_pready", int'(pready), 0);
    @(posedge pclk); #1;
    apb_read(BASE, 0, 1, "rst_period");
    apb_read(BASE + 32'd1, 0, 1, "rst_ctrl");
    apb_read(BASE + 32'd2, 0, 1, "rst_count");

    // Run for 50 enabled edges then stop; count holds
    apb_write(BASE, 200);
    apb_read(BASE, 200, 1, "period_rb");
    apb_write(BASE + 32'd1, 1);
    idle(48);
    apb_write(BASE + 32'd1, 0);
    apb_read(BASE + 32'd2, 50, 1, "count_stop");
    idle(10);
    apb_read(BASE + 32'd2, 50, 1, "count_hold");

    // Resume from 50: first pulse after 150 edges, then every 200
    apb_write(BASE + 32'd1, 1);
    edges_to_pulse(n);
    chk("resume_edges", n, 150);
    @(posedge pclk); #1;
    chk("pulse_width", int'(timeout), 0);
    n = 1;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!timeout && n < 600);
    chk("full_period", n, 200);

    // Period 3: pulse every 3rd edge, then CLR mid-period
    apb_write(BASE + 32'd1, 2);
    apb_write(BASE, 3);
    apb_write(BASE + 32'd1, 1);
    edges_to_pulse(n);
    chk("p3_first", n, 3);
    edges_to_pulse(n);
    chk("p3_second", n, 3);
    edges_to_pulse(n);
    chk("p3_third", n, 3);
    idle(1);
    apb_write(BASE + 32'd1, 3);
    apb_read(BASE + 32'd2, 1, 1, "count_after_clr");
    apb_read(BASE + 32'd1, 1, 1, "ctrl_clr_reads0");

    // Shrink period below count, then period 0
    apb_write(BASE + 32'd1, 2);
    apb_write(BASE, 200);
    apb_write(BASE + 32'd1, 1);
    idle(8);
    apb_write(BASE, 5);
    @(posedge pclk); #1;
    chk("shrink_expiry", int'(timeout), 1);
    apb_write(BASE, 0);
    p = 0;
    repeat (20) begin
      @(posedge pclk); #1;
      if (timeout) p++;
    end
    chk("period0_pulses", p, 0);
    apb_read(BASE + 32'd2, 0, 1, "period0_count");

    // Unmapped addresses, then reset mid-count
    apb_write(BASE, 7);
    apb_write(BASE + 32'd3, 255);
    apb_write(32'h0000_0000, 255);
    apb_read(BASE + 32'd3, 0, 1, "unmapped_3");
    apb_read(32'h0000_0000, 0, 1, "unmapped_0");
    apb_read(BASE, 7, 1, "period_kept");
    apb_read(BASE + 32'd1, 1, 1, "ctrl_kept");
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    chk("rst2_timeout", int'(timeout), 0);
    apb_read(BASE, 0, 1, "rst2_period");
    apb_read(BASE + 32'd1, 0, 1, "rst2_ctrl");
    apb_read(BASE + 32'd2, 0, 1, "rst2_count");

    // Randomized traffic; the per-cycle compare does the checking
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        preset = 1'b1;
        idle(1);
        preset = 1'b0;
      end else begin
        case ($urandom_range(0, 6))
          0, 1:    a = BASE;
          2, 3:    a = BASE + 32'd1;
          4:       a = BASE + 32'd2;
          5:       a = BASE + 32'd3;
          default: a = ($urandom_range(0, 1) == 1) ? 32'h0000_0000 : $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) begin
          if (a == BASE) d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : $urandom_range(1, 12);
          else if (a == BASE + 32'd1) d = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, 255);
          else d = $urandom_range(0, 255);
          apb_write(a, d);
        end else begin
          apb_read(a, 0, 0, "rand_rd");
        end
        idle($urandom_range(0, 6));
      end
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
